// File: rtl/gbf_fill_ctrl_pkg.sv
// rtl/gbf_fill_ctrl_pkg.sv - shared FSM state codes and buffer-select encoding
// for the global-buffer fill controller.
package gbf_fill_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_FILL   = 3'd2;
  localparam logic [2:0] ST_FLUSH  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic BUF1 = 1'b0;
  localparam logic BUF2 = 1'b1;

endpackage

// File: rtl/gbf_fill_wport.sv
// rtl/gbf_fill_wport.sv - registered port-a driver; steers one write to buf1 or buf2
// and holds every output of the idle buffer's port at zero.
module gbf_fill_wport
  import gbf_fill_ctrl_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic              target_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              en1_o,
  output logic              we1_o,
  output logic [ADDR_W-1:0] addr1_o,
  output logic [DATA_W-1:0] data1_o,
  output logic              en2_o,
  output logic              we2_o,
  output logic [ADDR_W-1:0] addr2_o,
  output logic [DATA_W-1:0] data2_o
);

  logic              sel1, sel2;
  logic              en1_q, en2_q;
  logic [ADDR_W-1:0] addr1_q, addr2_q;
  logic [DATA_W-1:0] data1_q, data2_q;

  assign sel1 = wr_en_i && (target_i == BUF1);
  assign sel2 = wr_en_i && (target_i == BUF2);

  always_ff @(posedge clk) begin
    if (reset) begin
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
      addr1_q <= '0;
      addr2_q <= '0;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      en1_q   <= sel1;
      en2_q   <= sel2;
      addr1_q <= sel1 ? addr_i : '0;
      addr2_q <= sel2 ? addr_i : '0;
      data1_q <= sel1 ? data_i : '0;
      data2_q <= sel2 ? data_i : '0;
    end
  end

  // Port a is write-only here, so enable and write-enable are the same strobe.
  assign en1_o   = en1_q;
  assign we1_o   = en1_q;
  assign addr1_o = addr1_q;
  assign data1_o = data1_q;
  assign en2_o   = en2_q;
  assign we2_o   = en2_q;
  assign addr2_o = addr2_q;
  assign data2_o = data2_q;

endmodule

// File: rtl/gbf_fill_ctrl.sv
// rtl/gbf_fill_ctrl.sv - fills fixed-length tiles alternately into a double-buffered
// global buffer from a valid/ready word stream and signals tile completion.
module gbf_fill_ctrl
  import gbf_fill_ctrl_pkg::*;
#(
  parameter int GBF_DATA_BITWIDTH = 512,
  parameter int GBF_ADDR_BITWIDTH = 5,
  parameter int GBF_DEPTH         = 32,
  parameter int TILE_CNT_BITWIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [TILE_CNT_BITWIDTH-1:0] num_tiles,
  input  logic [GBF_ADDR_BITWIDTH:0]   tile_len,
  input  logic                         buf1_need_data,
  input  logic                         buf2_need_data,
  input  logic                         in_valid,
  input  logic [GBF_DATA_BITWIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic                         fill_req,
  output logic [TILE_CNT_BITWIDTH-1:0] tile_idx,
  output logic                         en1a,
  output logic                         we1a,
  output logic                         en2a,
  output logic                         we2a,
  output logic [GBF_ADDR_BITWIDTH-1:0] addr1a,
  output logic [GBF_ADDR_BITWIDTH-1:0] addr2a,
  output logic [GBF_DATA_BITWIDTH-1:0] w_data1a,
  output logic [GBF_DATA_BITWIDTH-1:0] w_data2a,
  output logic                         buf1_ready,
  output logic                         buf2_ready,
  output logic                         data_avail,
  output logic                         done
);

  localparam int AW = GBF_ADDR_BITWIDTH;

  logic [2:0]                   state_q, state_d;
  logic [TILE_CNT_BITWIDTH-1:0] num_tiles_q, num_tiles_d;
  logic [TILE_CNT_BITWIDTH-1:0] tile_idx_q, tile_idx_d;
  logic [AW:0]                  len_q, len_d;
  logic [AW:0]                  word_cnt_q, word_cnt_d;
  logic [1:0]                   empty_q, empty_d;
  logic [1:0]                   need_q;
  logic [1:0]                   rdy_q, rdy_d;
  logic                         target_q, target_d;
  logic [1:0]                   need_rise, clear_empty;
  logic                         load, hs;

  assign need_rise = {buf2_need_data, buf1_need_data} & ~need_q;
  assign in_ready  = (state_q == ST_FILL);
  assign hs        = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    num_tiles_d = num_tiles_q;
    tile_idx_d  = tile_idx_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    target_d    = target_q;
    rdy_d       = 2'b00;
    clear_empty = 2'b00;
    load        = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load        = 1'b1;
          num_tiles_d = num_tiles;
          len_d       = (tile_len == '0) ? (AW+1)'(GBF_DEPTH) : tile_len;
          tile_idx_d  = '0;
          word_cnt_d  = '0;
          target_d    = BUF1;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        // A need edge arriving this cycle counts as empty so FILL follows at once.
        if (tile_idx_q == num_tiles_q) state_d = ST_DONE;
        else if (empty_q[target_q] || need_rise[target_q]) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (hs) begin
          if (word_cnt_q + 1'b1 == len_q) begin
            word_cnt_d = '0;
            state_d    = ST_FLUSH;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        rdy_d[target_q]       = 1'b1;
        clear_empty[target_q] = 1'b1;
        tile_idx_d            = tile_idx_q + 1'b1;
        target_d              = ~target_q;
        state_d               = ST_SELECT;
      end
      default: state_d = ST_IDLE;
    endcase
    // A need edge wins over the flush clear of the same flag.
    empty_d = load ? 2'b11 : ((empty_q & ~clear_empty) | need_rise);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      num_tiles_q <= '0;
      tile_idx_q  <= '0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      empty_q     <= 2'b00;
      need_q      <= 2'b00;
      rdy_q       <= 2'b00;
      target_q    <= BUF1;
    end else begin
      state_q     <= state_d;
      num_tiles_q <= num_tiles_d;
      tile_idx_q  <= tile_idx_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      empty_q     <= empty_d;
      need_q      <= {buf2_need_data, buf1_need_data};
      rdy_q       <= rdy_d;
      target_q    <= target_d;
    end
  end

  gbf_fill_wport #(
    .DATA_W (GBF_DATA_BITWIDTH),
    .ADDR_W (AW)
  ) u_wport (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (hs),
    .target_i (target_q),
    .addr_i   (word_cnt_q[AW-1:0]),
    .data_i   (in_data),
    .en1_o    (en1a),
    .we1_o    (we1a),
    .addr1_o  (addr1a),
    .data1_o  (w_data1a),
    .en2_o    (en2a),
    .we2_o    (we2a),
    .addr2_o  (addr2a),
    .data2_o  (w_data2a)
  );

  assign fill_req   = in_ready;
  assign tile_idx   = tile_idx_q;
  assign buf1_ready = rdy_q[0];
  assign buf2_ready = rdy_q[1];
  assign data_avail = (state_q == ST_SELECT) || (state_q == ST_FILL) || (state_q == ST_FLUSH);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_gbf_fill_ctrl.sv
// tb/tb_gbf_fill_ctrl.sv - directed self-checking bench for gbf_fill_ctrl.
module tb_gbf_fill_ctrl;

  logic         clk = 1'b0;
  logic         reset, start, buf1_need_data, buf2_need_data, in_valid;
  logic [15:0]  num_tiles;
  logic [5:0]   tile_len;
  logic [511:0] in_data;
  logic         in_ready, fill_req, en1a, we1a, en2a, we2a;
  logic [15:0]  tile_idx;
  logic [4:0]   addr1a, addr2a;
  logic [511:0] w_data1a, w_data2a;
  logic         buf1_ready, buf2_ready, data_avail, done;

  gbf_fill_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles), .tile_len(tile_len),
    .buf1_need_data(buf1_need_data), .buf2_need_data(buf2_need_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .fill_req(fill_req),
    .tile_idx(tile_idx), .en1a(en1a), .we1a(we1a), .en2a(en2a), .we2a(we2a),
    .addr1a(addr1a), .addr2a(addr2a), .w_data1a(w_data1a), .w_data2a(w_data2a),
    .buf1_ready(buf1_ready), .buf2_ready(buf2_ready), .data_avail(data_avail), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; bit b; int addr; int data; } wr_t;
  typedef struct { int cyc; bit b; } rd_t;
  wr_t wlog[$];
  rd_t rlog[$];

  int n_cmp = 0, n_err = 0, cyc = 0, t0 = 0, word = 0;
  bit auto1 = 0, auto2 = 0;

  always @(negedge clk) begin
    if (en1a && we1a) wlog.push_back('{cyc, 1'b0, int'(addr1a), int'(w_data1a[31:0])});
    if (en2a && we2a) wlog.push_back('{cyc, 1'b1, int'(addr2a), int'(w_data2a[31:0])});
    if (buf1_ready) rlog.push_back('{cyc, 1'b0});
    if (buf2_ready) rlog.push_back('{cyc, 1'b1});
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream source advances its word on each accepted handshake.
  task automatic step();
    if (in_valid && in_ready) word++;
    @(posedge clk);
    #1;
    cyc++;
    in_data        = 512'(word);
    buf1_need_data = auto1 & buf1_ready;
    buf2_need_data = auto2 & buf2_ready;
  endtask

  function automatic logic [37:0] outs();
    return {in_ready, fill_req, tile_idx, en1a, we1a, en2a, we2a, addr1a, addr2a,
            |w_data1a, |w_data2a, buf1_ready, buf2_ready, data_avail, done};
  endfunction

  task automatic begin_layer(input int nt, input int tl);
    wlog.delete();
    rlog.delete();
    word      = 0;
    in_data   = '0;
    num_tiles = 16'(nt);
    tile_len  = 6'(tl);
    start     = 1'b1;
    t0        = cyc;
    step();
    start     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; buf1_need_data = 1'b0; buf2_need_data = 1'b0;
    in_valid = 1'b0; in_data = '0; num_tiles = '0; tile_len = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("reset_outs", 512'(outs()), 512'(0));

    // Three tiles of 4, buf1 re-requested right after its first ready pulse.
    auto1 = 1; auto2 = 0; in_valid = 1'b1;
    begin_layer(3, 4);
    chk("B_sel_avail", 512'(data_avail), 512'(1));
    chk("B_sel_fillreq", 512'(fill_req), 512'(0));
    step();
    chk("B_fill_req", 512'({fill_req, in_ready}), 512'(2'b11));
    chk("B_tile_idx0", 512'(tile_idx), 512'(0));
    step();
    start = 1'b1; num_tiles = 16'd9;
    step();
    start = 1'b0;
    while (!done && cyc < t0 + 40) step();
    chk("B_done_cyc", 512'(cyc - t0), 512'(20));
    chk("B_done_avail", 512'({done, data_avail}), 512'(2'b10));
    chk("B_tile_idx3", 512'(tile_idx), 512'(3));
    chk("B_nwr", 512'(wlog.size()), 512'(12));
    for (int i = 0; i < 12; i++)
      if (i < wlog.size())
        chk($sformatf("B_wr%0d", i), {wlog[i].b, wlog[i].addr, wlog[i].data, wlog[i].cyc},
            {(i / 4 == 1), i % 4, i, t0 + 3 + (i / 4) * 6 + i % 4});
    chk("B_nrdy", 512'(rlog.size()), 512'(3));
    for (int i = 0; i < 3; i++)
      if (i < rlog.size())
        chk($sformatf("B_rdy%0d", i), {rlog[i].b, rlog[i].cyc}, {(i == 1), t0 + 7 + 6 * i});

    // Four tiles of 2 restarted from DONE; buf2 edge withheld before the fourth tile.
    begin_layer(4, 2);
    chk("C_restart", 512'({done, data_avail}), 512'(2'b01));
    while (cyc < t0 + 13) step();
    chk("C_tile_idx3", 512'(tile_idx), 512'(3));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("C_wait%0d", k), 512'({fill_req, in_ready, data_avail}), 512'(3'b001));
      step();
    end
    buf2_need_data = 1'b1;
    step();
    chk("C_fill_after_edge", 512'({fill_req, in_ready}), 512'(2'b11));
    while (!done && cyc < t0 + 40) step();
    chk("C_done_cyc", 512'(cyc - t0), 512'(21));
    chk("C_tile_idx4", 512'(tile_idx), 512'(4));
    chk("C_nwr", 512'(wlog.size()), 512'(8));
    if (wlog.size() == 8) begin
      chk("C_wr4", {wlog[4].b, wlog[4].addr, wlog[4].data, wlog[4].cyc}, {1'b0, 32'd0, 32'd4, t0 + 11});
      chk("C_wr7", {wlog[7].b, wlog[7].addr, wlog[7].data, wlog[7].cyc}, {1'b1, 32'd1, 32'd7, t0 + 19});
    end
    chk("C_nrdy", 512'(rlog.size()), 512'(4));
    if (rlog.size() == 4)
      chk("C_rdy3", {rlog[3].b, rlog[3].cyc}, {1'b1, t0 + 20});

    // tile_len 0 means a full 32-word tile.
    auto1 = 0;
    begin_layer(1, 0);
    while (!done && cyc < t0 + 60) step();
    chk("D_done_cyc", 512'(cyc - t0), 512'(36));
    chk("D_nwr", 512'(wlog.size()), 512'(32));
    for (int i = 0; i < 32; i++)
      if (i < wlog.size())
        chk($sformatf("D_wr%0d", i), {wlog[i].b, wlog[i].addr, wlog[i].data, wlog[i].cyc},
            {1'b0, i, i, t0 + 3 + i});
    if (rlog.size() > 0) chk("D_rdy", {rlog[0].b, rlog[0].cyc}, {1'b0, t0 + 35});
    else chk("D_rdy_missing", 512'(rlog.size()), 512'(1));

    // in_valid only on odd cycles from 3: handshakes at 3,5,7,9.
    in_valid = 1'b0;
    begin_layer(1, 4);
    while (!done && cyc < t0 + 40) begin
      step();
      in_valid = ((cyc - t0) >= 3) && ((cyc - t0) % 2 == 1);
    end
    chk("E_nwr", 512'(wlog.size()), 512'(4));
    for (int i = 0; i < 4; i++)
      if (i < wlog.size())
        chk($sformatf("E_wr%0d", i), {wlog[i].addr, wlog[i].data, wlog[i].cyc}, {i, i, t0 + 4 + 2 * i});
    if (rlog.size() > 0) chk("E_rdy", 512'(rlog[0].cyc), 512'(t0 + 11));
    else chk("E_rdy_missing", 512'(rlog.size()), 512'(1));

    // Reset during the third handshake of a 4-word tile, then restart.
    in_valid = 1'b1;
    begin_layer(2, 4);
    step(); step(); step();
    reset = 1'b1;
    step();
    chk("F_reset_outs", 512'(outs()), 512'(0));
    chk("F_nwr", 512'(wlog.size()), 512'(2));
    reset = 1'b0;
    begin_layer(2, 4);
    while (!done && cyc < t0 + 40) step();
    chk("F_done_cyc", 512'(cyc - t0), 512'(14));
    chk("F_nwr2", 512'(wlog.size()), 512'(8));
    if (wlog.size() == 8) begin
      chk("F_wr0", {wlog[0].b, wlog[0].addr, wlog[0].data, wlog[0].cyc}, {1'b0, 32'd0, 32'd0, t0 + 3});
      chk("F_wr4", {wlog[4].b, wlog[4].addr, wlog[4].data, wlog[4].cyc}, {1'b1, 32'd0, 32'd4, t0 + 9});
    end

    // num_tiles = 0 from IDLE.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    begin_layer(0, 4);
    chk("G_sel", 512'({done, data_avail}), 512'(2'b01));
    step();
    chk("G_done", 512'({done, data_avail, fill_req}), 512'(3'b100));
    step();
    chk("G_nwr", 512'(wlog.size() + rlog.size()), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
